// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the framed test-pattern generator and its
// receive-side checker: FSM states, payload mode codes and default frame words.
package frame_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEAD    = 2'd1,
    PAYLOAD = 2'd2,
    TAIL    = 2'd3
  } state_t;

  localparam logic [1:0] MODE_PRBS  = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_FIXED = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  localparam logic [9:0] DEF_HEAD_WORD = 10'b1100110011;
  localparam logic [9:0] DEF_TAIL_WORD = 10'b1100110011;

endpackage

// File: rtl/prbs_lfsr.sv
// Parallel Fibonacci LFSR (x^POLY_LENGTH + x^POLY_TAP + 1) that advances DATA_W
// bits per step; data previews the word the next step produces, oldest bit as MSB.
module prbs_lfsr #(
  parameter int POLY_LENGTH = 9,
  parameter int POLY_TAP    = 5,
  parameter int INV_PATTERN = 1,
  parameter int DATA_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic              step,
  output logic [DATA_W-1:0] data
);

  logic [POLY_LENGTH-1:0] lfsr;
  logic [POLY_LENGTH-1:0] lfsr_next;
  logic [POLY_LENGTH-1:0] work;
  logic [DATA_W-1:0]      bits;
  logic                   fb;

  // Unroll DATA_W serial shifts so one step emits a whole word.
  always_comb begin
    work = lfsr;
    bits = '0;
    fb   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      fb                 = work[POLY_LENGTH-1] ^ work[POLY_TAP-1];
      bits[DATA_W-1-i]   = fb;
      work               = {work[POLY_LENGTH-2:0], fb};
    end
    lfsr_next = work;
    data      = (INV_PATTERN != 0) ? ~bits : bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '1;
    end else if (seed_load) begin
      lfsr <= '1;
    end else if (step) begin
      lfsr <= lfsr_next;
    end
  end

endmodule

// File: rtl/frame_gen.sv
// Framed test-pattern generator: header, programmable payload (PRBS, ramp,
// fixed, alternating) and tail over a valid/ready stream with registered outputs.
module frame_gen
  import frame_gen_pkg::*;
#(
  parameter int                DATA_W      = 10,
  parameter int                LEN_W       = 11,
  parameter int                POLY_LENGTH = 9,
  parameter int                POLY_TAP    = 5,
  parameter int                INV_PATTERN = 1,
  parameter logic [DATA_W-1:0] HEAD_WORD   = DEF_HEAD_WORD,
  parameter logic [DATA_W-1:0] TAIL_WORD   = DEF_TAIL_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fixed_word,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  state_t            state, state_next;
  logic [LEN_W-1:0]  idx, next_idx, len_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fixed_q, prbs_word, payload_word;
  logic              accept, upd, take_start, last_beat;

  assign accept    = out_valid && out_ready;
  // Output registers reload whenever the presented word is gone or was never there.
  assign upd       = !out_valid || out_ready || (state_next == IDLE);
  assign last_beat = (idx == len_q - LEN_W'(1));
  assign next_idx  = (state == HEAD) ? '0 : idx + LEN_W'(1);

  always_comb begin
    state_next = state;
    take_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = HEAD;
          take_start = 1'b1;
        end
      end
      HEAD: begin
        if (accept) state_next = (len_q == '0) ? TAIL : PAYLOAD;
      end
      PAYLOAD: begin
        if (accept && last_beat) state_next = TAIL;
      end
      TAIL: begin
        if (accept) begin
          if (start) begin
            state_next = HEAD;
            take_start = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  prbs_lfsr #(
    .POLY_LENGTH(POLY_LENGTH),
    .POLY_TAP   (POLY_TAP),
    .INV_PATTERN(INV_PATTERN),
    .DATA_W     (DATA_W)
  ) u_prbs (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed_load(upd && (state_next == HEAD)),
    .step     (upd && (state_next == PAYLOAD)),
    .data     (prbs_word)
  );

  always_comb begin
    payload_word = '0;
    case (mode_q)
      MODE_PRBS:  payload_word = prbs_word;
      MODE_RAMP:  payload_word = DATA_W'(next_idx);
      MODE_FIXED: payload_word = fixed_q;
      MODE_ALT:   payload_word = next_idx[0] ? ~fixed_q : fixed_q;
      default:    payload_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      mode_q    <= MODE_PRBS;
      fixed_q   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      if (take_start) begin
        len_q   <= payload_len;
        mode_q  <= mode;
        fixed_q <= fixed_word;
      end
      if (state_next == HEAD) begin
        idx <= '0;
      end else if (upd && (state_next == PAYLOAD)) begin
        idx <= next_idx;
      end
      if ((state == TAIL) && accept) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (upd) begin
        out_valid <= 1'b0;
        data_out  <= '0;
        sof       <= 1'b0;
        eof       <= 1'b0;
        case (state_next)
          HEAD: begin
            out_valid <= 1'b1;
            data_out  <= HEAD_WORD;
            sof       <= 1'b1;
          end
          PAYLOAD: begin
            out_valid <= 1'b1;
            data_out  <= payload_word;
          end
          TAIL: begin
            out_valid <= 1'b1;
            data_out  <= TAIL_WORD;
            eof       <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_gen.sv
// Scoreboard bench for frame_gen: expected beats are queued from a bit-stream
// reference model and compared by a monitor on every accepted word.
module tb_frame_gen;
  import frame_gen_pkg::*;

  localparam int DATA_W = 10;
  localparam int LEN_W  = 11;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  payload_len;
  logic [1:0]        mode;
  logic [DATA_W-1:0] fixed_word;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] data_out;
  logic              sof;
  logic              eof;
  logic              busy;
  logic [15:0]       frame_cnt;

  frame_gen #(
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .POLY_LENGTH(9),
    .POLY_TAP   (5),
    .INV_PATTERN(1),
    .HEAD_WORD  (10'h333),
    .TAIL_WORD  (10'h333)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .payload_len(payload_len),
    .mode       (mode),
    .fixed_word (fixed_word),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .data_out   (data_out),
    .sof        (sof),
    .eof        (eof),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
  } beat_t;

  beat_t exp_q[$];
  int    checks     = 0;
  int    failures   = 0;
  int    exp_frames = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference frame: PRBS bits follow b[n] = b[n-9] ^ b[n-5] from nine leading ones.
  task automatic push_frame(input int len, input logic [1:0] m, input logic [DATA_W-1:0] fw);
    bit                hist[$];
    logic [DATA_W-1:0] w;
    beat_t             b;
    for (int i = 0; i < 9; i++) hist.push_back(1'b1);
    b = '{data: 10'h333, sof: 1'b1, eof: 1'b0};
    exp_q.push_back(b);
    for (int k = 0; k < len; k++) begin
      w = '0;
      case (m)
        MODE_PRBS: begin
          for (int j = 0; j < DATA_W; j++) begin
            bit nb;
            nb = hist[hist.size()-9] ^ hist[hist.size()-5];
            hist.push_back(nb);
            w = {w[DATA_W-2:0], nb};
          end
          w = ~w;
        end
        MODE_RAMP:  w = DATA_W'(k);
        MODE_FIXED: w = fw;
        default:    w = (k % 2 == 1) ? ~fw : fw;
      endcase
      b = '{data: w, sof: 1'b0, eof: 1'b0};
      exp_q.push_back(b);
    end
    b = '{data: 10'h333, sof: 1'b0, eof: 1'b1};
    exp_q.push_back(b);
  endtask

  // Monitor: pops on every accepted beat and checks hold-stability across stalls.
  logic              pv, pr, ps, pe;
  logic [DATA_W-1:0] pd;
  beat_t             mon_beat;
  initial begin
    pv = 1'b0; pr = 1'b0; ps = 1'b0; pe = 1'b0; pd = '0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr) begin
        check_output("stall_valid", 32'(out_valid), 32'(1));
        check_output("stall_data", 32'(data_out), 32'(pd));
        check_output("stall_flags", 32'({sof, eof}), 32'({ps, pe}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat actual=%0h required=none at %0t", data_out, $time);
        end else begin
          mon_beat = exp_q.pop_front();
          check_output("beat_data", 32'(data_out), 32'(mon_beat.data));
          check_output("beat_sof", 32'(sof), 32'(mon_beat.sof));
          check_output("beat_eof", 32'(eof), 32'(mon_beat.eof));
        end
      end
    end
    pv = out_valid && rst_n;
    pr = out_ready;
    pd = data_out;
    ps = sof;
    pe = eof;
  end

  task automatic apply_frame(input int len, input logic [1:0] m, input logic [DATA_W-1:0] fw,
                             input int ready_pct, input bit scramble);
    int cyc;
    push_frame(len, m, fw);
    payload_len = LEN_W'(len);
    mode        = m;
    fixed_word  = fw;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("start_valid", 32'(out_valid), 32'(1));
    check_output("start_sof", 32'(sof), 32'(1));
    check_output("start_head", 32'(data_out), 32'(10'h333));
    cyc = 0;
    while (busy && cyc < 5000) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (scramble) begin
        payload_len = LEN_W'($urandom);
        mode        = 2'($urandom);
        fixed_word  = DATA_W'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL frame_timeout actual=busy required=idle at %0t", $time);
    end
    exp_frames++;
    check_output("frame_cnt", 32'(frame_cnt), 32'(exp_frames & 16'hFFFF));
    check_output("idle_valid", 32'(out_valid), 32'(0));
    check_output("idle_data", 32'(data_out), 32'(0));
    check_output("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cycles;
    int tails;
    int cyc;
    rst_n       = 1'b0;
    start       = 1'b0;
    payload_len = '0;
    mode        = MODE_PRBS;
    fixed_word  = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_valid", 32'(out_valid), 32'(0));
    check_output("rst_data", 32'(data_out), 32'(0));
    check_output("rst_sof", 32'(sof), 32'(0));
    check_output("rst_eof", 32'(eof), 32'(0));
    check_output("rst_busy", 32'(busy), 32'(0));
    check_output("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    apply_frame(3, MODE_RAMP, 10'h000, 100, 1'b0);
    apply_frame(8, MODE_PRBS, 10'h000, 100, 1'b0);
    apply_frame(8, MODE_PRBS, 10'h000, 100, 1'b0);
    apply_frame(4, MODE_ALT, 10'h155, 50, 1'b1);

    // Three zero-length frames with start held through each tail.
    push_frame(0, MODE_RAMP, 10'h000);
    push_frame(0, MODE_RAMP, 10'h000);
    push_frame(0, MODE_RAMP, 10'h000);
    payload_len = '0;
    mode        = MODE_RAMP;
    out_ready   = 1'b1;
    start       = 1'b1;
    busy_cycles = 0;
    tails       = 0;
    cyc         = 0;
    @(posedge clk); #1;
    while (busy && cyc < 50) begin
      busy_cycles++;
      if (out_valid && eof) begin
        tails++;
        if (tails == 3) start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    exp_frames += 3;
    check_output("b2b_busy_cycles", 32'(busy_cycles), 32'(6));
    check_output("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Reset in the middle of a PRBS payload, then restart cleanly.
    push_frame(8, MODE_PRBS, 10'h000);
    payload_len = LEN_W'(8);
    mode        = MODE_PRBS;
    out_ready   = 1'b1;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_output("async_rst_valid", 32'(out_valid), 32'(0));
    check_output("async_rst_data", 32'(data_out), 32'(0));
    check_output("async_rst_busy", 32'(busy), 32'(0));
    check_output("async_rst_frame_cnt", 32'(frame_cnt), 32'(0));
    exp_q.delete();
    exp_frames = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_frame(8, MODE_PRBS, 10'h000, 100, 1'b0);

    apply_frame(2047, MODE_RAMP, 10'h000, 100, 1'b0);
    apply_frame(0, MODE_FIXED, 10'h2A5, 70, 1'b1);

    for (int f = 0; f < 30; f++) begin
      apply_frame($urandom_range(0, 20), 2'($urandom), DATA_W'($urandom),
                  $urandom_range(30, 100), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_gen.md
# frame_gen

Parametrised framed test-pattern generator for the colour-filter link test path. It emits a frame of one header word, a runtime-programmable number of payload words, and one tail word over a valid/ready stream. Payload source is selectable per frame: PRBS, ramp, fixed word or alternating pattern. It sits ahead of the serialiser/lane mapper and pairs with the receive-side frame checker.

## Interface
- DATA_W, 10: word width.
- LEN_W, 11: width of payload length; max payload is 2^LEN_W−1 words.
- POLY_LENGTH, 9: LFSR length (x^POLY_LENGTH + x^POLY_TAP + 1).
- POLY_TAP, 5: LFSR feedback tap.
- INV_PATTERN, 1: invert PRBS output bits when 1.
- HEAD_WORD, 10'b1100110011: header word.
- TAIL_WORD, 10'b1100110011: tail word.
---
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a frame; sampled in IDLE, and on tail acceptance.
- payload_len  in  LEN_W  payload words for the frame; latched at start.
- mode  in  2  payload source; latched at start. 0 = PRBS, 1 = ramp, 2 = fixed, 3 = alternating.
- fixed_word  in  DATA_W  payload for modes 2/3; latched at start.
- out_ready  in  1  downstream accepts the word.
- out_valid  out  1  data_out holds a valid word.
- data_out  out  DATA_W  stream word.
- sof  out  1  high with the header word.
- eof  out  1  high with the tail word.
- busy  out  1  high whenever state ≠ IDLE.
- frame_cnt  out  16  count of completed frames; wraps at 16'hFFFF→0.

## Operation
- A word is accepted when out_valid && out_ready. Every state advance requires acceptance.
- FSM states:
  - IDLE: start → HEAD.
  - HEAD, accepted: go to PAYLOAD, or to TAIL if latched len = 0.
  - PAYLOAD: stays until idx = len−1 is accepted, then goes to TAIL.
  - TAIL, accepted: go to HEAD if start = 1, else IDLE.
  - An illegal state encoding recovers to IDLE.
- The payload index idx resets to 0 on entry to HEAD.
- Payload word by mode:
  - PRBS: LFSR is reseeded to all-ones at HEAD. It steps DATA_W bits per accepted payload word; the word is the DATA_W newest bits, MSB first, inverted if INV_PATTERN.
  - Ramp: idx, truncated to DATA_W.
  - Fixed: fixed_word every beat.
  - Alternating: fixed_word on even idx, ~fixed_word on odd idx.
- Config (payload_len, mode, fixed_word) is latched when start is taken. Input changes mid-frame are ignored.
- frame_cnt increments on tail acceptance.

## Timing
- All outputs are registered. Reset values: out_valid 0, data_out 0, sof 0, eof 0, busy 0, frame_cnt 0. FSM goes to IDLE, LFSR to all-ones.
- Start latency: start sampled high in IDLE at edge N gives out_valid = 1 with HEAD_WORD and sof from edge N+1.
- Frame length: exactly len+2 accepted beats. With out_ready tied 1 there are no gaps.
- Back-to-back frames: start high during tail acceptance gives HEAD on the very next cycle, with no IDLE gap.
- Stall: while out_valid && !out_ready, data_out, sof and eof hold stable and neither the LFSR nor idx advances.
- In IDLE: out_valid = 0 and data_out = 0.
- Reset asserted mid-frame: outputs clear asynchronously. After release the FSM is in IDLE and waits for start; no partial frame resumes.
- Maximum length: len = 2^LEN_W−1. The idx compare must not overflow.

## Structure
- Package frame_gen_pkg holds the state enum (IDLE, HEAD, PAYLOAD, TAIL), the mode constants, and the default HEAD/TAIL words.
- Sub-module prbs_lfsr (parameters POLY_LENGTH, POLY_TAP, INV_PATTERN, DATA_W):
  - ports clk, rst_n, seed_load, step, data.
  - Parallel Fibonacci LFSR advancing DATA_W bits per step.
  - Reusable by the checker.
- Top-level: FSM, idx counter, config latch, output mux/register.

## Test plan
- Ramp, len = 3, out_ready = 1, start pulsed: beats 0x333 (sof), 0, 1, 2, 0x333 (eof). frame_cnt = 1 and busy drops the cycle after the tail.
- PRBS9, len = 8, INV_PATTERN = 1: 8 payload words match the bit-accurate model seeded all-ones. A second frame repeats identical payload because of the reseed.
- Alternating, fixed_word = 0x155, len = 4, random out_ready stalls: payload is 0x155, 0x2AA, 0x155, 0x2AA. data_out is stable during every stall.
- len = 0 and start held high for 3 frames: stream is HEAD, TAIL, HEAD, TAIL, HEAD, TAIL with no gap; frame_cnt = 3.
- rst_n asserted at PAYLOAD idx = 2, then released with start = 1: outputs go to 0 immediately. The next frame begins with HEAD, and its payload restarts from idx 0 / seed.
- mode and payload_len changed mid-frame: the current frame is unaffected; the next frame uses the new values.
